// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - RISC-V decode/operand-fetch stage with pending-write scoreboard
// Latches one instruction, builds operands and immediates, and stalls on RAW or counter-full hazards.
module decode_stage #(
   parameter int XLEN   = 32,
   parameter int PEND_W = 2
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [31:0]       in_inst,
   input  logic [XLEN-1:0]   in_pc,
   input  logic              flush,
   output logic [4:0]        rf_rs1_sel,
   output logic [4:0]        rf_rs2_sel,
   input  logic [XLEN-1:0]   rf_rs1_data,
   input  logic [XLEN-1:0]   rf_rs2_data,
   input  logic              wb_en,
   input  logic [4:0]        wb_rd,
   input  logic [XLEN-1:0]   wb_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [XLEN-1:0]   out_pc,
   output logic [XLEN-1:0]   out_rs1,
   output logic [XLEN-1:0]   out_rs2,
   output logic [XLEN-1:0]   out_imm_i,
   output logic [XLEN-1:0]   out_imm_s,
   output logic [XLEN-1:0]   out_imm_b,
   output logic [XLEN-1:0]   out_imm_u,
   output logic [XLEN-1:0]   out_imm_j,
   output logic [6:0]        out_opcode,
   output logic [2:0]        out_funct3,
   output logic [6:0]        out_funct7,
   output logic [4:0]        out_rd,
   output logic              out_illegal
);

   localparam logic IS64 = (XLEN == 64);
   localparam logic [6:0] OPC_LUI     = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
   localparam logic [6:0] OPC_JAL     = 7'b1101111;
   localparam logic [6:0] OPC_JALR    = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
   localparam logic [6:0] OPC_LOAD    = 7'b0000011;
   localparam logic [6:0] OPC_STORE   = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
   localparam logic [6:0] OPC_OP      = 7'b0110011;
   localparam logic [6:0] OPC_MISC    = 7'b0001111;
   localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;
   localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
   localparam logic [6:0] OPC_OP32    = 7'b0111011;
   localparam logic [PEND_W-1:0] PEND_MAX = {PEND_W{1'b1}};

   logic              out_valid_q, held_wr_q, out_illegal_q;
   logic [XLEN-1:0]   out_pc_q, out_rs1_q, out_rs2_q;
   logic [XLEN-1:0]   imm_i_q, imm_s_q, imm_b_q, imm_u_q, imm_j_q;
   logic [6:0]        out_opcode_q, out_funct7_q;
   logic [2:0]        out_funct3_q;
   logic [4:0]        out_rd_q;
   logic [PEND_W-1:0] pend_q [32];

   logic [4:0]        rs1, rs2, rd;
   logic              legal, wr_cls, rd_rs1, rd_rs2, in_wr;
   logic              hz1, hz2, hz_full, hazard, fire, accept;
   logic [31:0]       inc_v, dec_v;
   logic [XLEN-1:0]   rs1_d, rs2_d;
   logic [31:0]       imm_i32, imm_s32, imm_b32, imm_u32, imm_j32;

   assign rs1 = in_inst[19:15];
   assign rs2 = in_inst[24:20];
   assign rd  = in_inst[11:7];
   assign rf_rs1_sel = rs1;
   assign rf_rs2_sel = rs2;

   always_comb begin
      legal  = 1'b0;
      wr_cls = 1'b0;
      rd_rs1 = 1'b0;
      rd_rs2 = 1'b0;
      case (in_inst[6:0])
         OPC_LUI, OPC_AUIPC, OPC_JAL: begin
            legal = 1'b1; wr_cls = 1'b1;
         end
         OPC_JALR, OPC_LOAD, OPC_OPIMM: begin
            legal = 1'b1; wr_cls = 1'b1; rd_rs1 = 1'b1;
         end
         OPC_OP: begin
            legal = 1'b1; wr_cls = 1'b1; rd_rs1 = 1'b1; rd_rs2 = 1'b1;
         end
         OPC_BRANCH, OPC_STORE: begin
            legal = 1'b1; rd_rs1 = 1'b1; rd_rs2 = 1'b1;
         end
         OPC_MISC, OPC_SYSTEM: begin
            legal = 1'b1; rd_rs1 = 1'b1;
         end
         OPC_OPIMM32: begin
            legal = IS64; wr_cls = IS64; rd_rs1 = IS64;
         end
         OPC_OP32: begin
            legal = IS64; wr_cls = IS64; rd_rs1 = IS64; rd_rs2 = IS64;
         end
         default: ;
      endcase
   end

   assign in_wr = wr_cls && (rd != 5'd0);

   // A source is blocked by the held producer (even while it fires) or by any write
   // still outstanding, unless the only outstanding write lands this very cycle.
   function automatic logic src_hz(input logic [4:0] rs, input logic [PEND_W-1:0] p,
                                   input logic held_hit, input logic wb_hit);
      return (rs != 5'd0) && (held_hit || (p >= PEND_W'(2)) || ((p == PEND_W'(1)) && !wb_hit));
   endfunction

   assign hz1 = rd_rs1 && src_hz(rs1, pend_q[rs1],
                                 out_valid_q && held_wr_q && (out_rd_q == rs1),
                                 wb_en && (wb_rd == rs1));
   assign hz2 = rd_rs2 && src_hz(rs2, pend_q[rs2],
                                 out_valid_q && held_wr_q && (out_rd_q == rs2),
                                 wb_en && (wb_rd == rs2));
   assign hz_full = in_wr && (pend_q[rd] == PEND_MAX);
   assign hazard  = hz1 || hz2 || hz_full;

   assign in_ready = reset && !flush && (!out_valid_q || out_ready) && !(in_valid && hazard);
   assign fire     = out_valid_q && out_ready;
   assign accept   = in_valid && in_ready;

   assign inc_v = (fire && held_wr_q) ? (32'd1 << out_rd_q) : 32'd0;
   assign dec_v = (wb_en && (wb_rd != 5'd0) && (pend_q[wb_rd] != '0)) ? (32'd1 << wb_rd) : 32'd0;

   assign rs1_d = (rs1 == 5'd0) ? '0 : (wb_en && (wb_rd == rs1)) ? wb_data : rf_rs1_data;
   assign rs2_d = (rs2 == 5'd0) ? '0 : (wb_en && (wb_rd == rs2)) ? wb_data : rf_rs2_data;

   assign imm_i32 = {{20{in_inst[31]}}, in_inst[31:20]};
   assign imm_s32 = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
   assign imm_b32 = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
   assign imm_u32 = {in_inst[31:12], 12'b0};
   assign imm_j32 = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};

   always_ff @(posedge clock) begin
      if (!reset) begin
         out_valid_q   <= 1'b0;
         held_wr_q     <= 1'b0;
         out_illegal_q <= 1'b0;
         out_pc_q      <= '0;
         out_rs1_q     <= '0;
         out_rs2_q     <= '0;
         imm_i_q       <= '0;
         imm_s_q       <= '0;
         imm_b_q       <= '0;
         imm_u_q       <= '0;
         imm_j_q       <= '0;
         out_opcode_q  <= '0;
         out_funct3_q  <= '0;
         out_funct7_q  <= '0;
         out_rd_q      <= '0;
         for (int r = 0; r < 32; r++) pend_q[r] <= '0;
      end else if (flush) begin
         out_valid_q <= 1'b0;
         for (int r = 0; r < 32; r++) pend_q[r] <= '0;
      end else begin
         for (int r = 0; r < 32; r++) begin
            if (inc_v[r] && !dec_v[r])
               pend_q[r] <= pend_q[r] + PEND_W'(1);
            else if (dec_v[r] && !inc_v[r])
               pend_q[r] <= pend_q[r] - PEND_W'(1);
         end
         if (accept) begin
            out_valid_q   <= 1'b1;
            held_wr_q     <= in_wr;
            out_illegal_q <= !legal;
            out_pc_q      <= in_pc;
            out_rs1_q     <= rd_rs1 ? rs1_d : rs1_d;
            out_rs2_q     <= rs2_d;
            imm_i_q       <= XLEN'($signed(imm_i32));
            imm_s_q       <= XLEN'($signed(imm_s32));
            imm_b_q       <= XLEN'($signed(imm_b32));
            imm_u_q       <= XLEN'($signed(imm_u32));
            imm_j_q       <= XLEN'($signed(imm_j32));
            out_opcode_q  <= in_inst[6:0];
            out_funct3_q  <= in_inst[14:12];
            out_funct7_q  <= in_inst[31:25];
            out_rd_q      <= rd;
         end else if (fire) begin
            out_valid_q <= 1'b0;
         end
      end
   end

   assign out_valid   = out_valid_q;
   assign out_pc      = out_pc_q;
   assign out_rs1     = out_rs1_q;
   assign out_rs2     = out_rs2_q;
   assign out_imm_i   = imm_i_q;
   assign out_imm_s   = imm_s_q;
   assign out_imm_b   = imm_b_q;
   assign out_imm_u   = imm_u_q;
   assign out_imm_j   = imm_j_q;
   assign out_opcode  = out_opcode_q;
   assign out_funct3  = out_funct3_q;
   assign out_funct7  = out_funct7_q;
   assign out_rd      = out_rd_q;
   assign out_illegal = out_illegal_q;

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - self-checking bench for decode_stage (XLEN=64, PEND_W=2)
module tb_decode_stage;

   localparam logic [6:0] LUI = 7'b0110111, AUIPC = 7'b0010111, JAL = 7'b1101111,
                          JALR = 7'b1100111, BRANCH = 7'b1100011, LOAD = 7'b0000011,
                          STORE = 7'b0100011, OPIMM = 7'b0010011, OP = 7'b0110011,
                          MISC = 7'b0001111, SYSTEM = 7'b1110011, OPIMM32 = 7'b0011011,
                          OP32 = 7'b0111011;

   logic        clock, reset, in_valid, in_ready, flush, wb_en, out_valid, out_ready, out_illegal;
   logic [31:0] in_inst;
   logic [63:0] in_pc, rf_rs1_data, rf_rs2_data, wb_data;
   logic [4:0]  rf_rs1_sel, rf_rs2_sel, wb_rd, out_rd;
   logic [63:0] out_pc, out_rs1, out_rs2, out_imm_i, out_imm_s, out_imm_b, out_imm_u, out_imm_j;
   logic [6:0]  out_opcode, out_funct7;
   logic [2:0]  out_funct3;
   logic [63:0] rf [32];

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [63:0] pc, rs1, rs2, ii, is, ib, iu, ij;
      logic [6:0]  opc, f7;
      logic [2:0]  f3;
      logic [4:0]  rd;
      logic        ill, wr;
   } ent_t;

   typedef struct {
      logic [31:0] inst;
      logic [63:0] ii, ib, iu;
      logic        ill;
      logic [6:0]  opc;
   } vec_t;

   ent_t       m_held;
   bit         m_v;
   int         m_pend [32];
   int         retire_q [$];
   logic [6:0] ops [15];
   vec_t       tbl [7];

   decode_stage #(.XLEN(64), .PEND_W(2)) dut (
      .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .in_inst(in_inst), .in_pc(in_pc), .flush(flush),
      .rf_rs1_sel(rf_rs1_sel), .rf_rs2_sel(rf_rs2_sel),
      .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data),
      .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
      .out_rs1(out_rs1), .out_rs2(out_rs2),
      .out_imm_i(out_imm_i), .out_imm_s(out_imm_s), .out_imm_b(out_imm_b),
      .out_imm_u(out_imm_u), .out_imm_j(out_imm_j),
      .out_opcode(out_opcode), .out_funct3(out_funct3), .out_funct7(out_funct7),
      .out_rd(out_rd), .out_illegal(out_illegal)
   );

   assign rf_rs1_data = rf[rf_rs1_sel];
   assign rf_rs2_data = rf[rf_rs2_sel];

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic void classify(input logic [31:0] inst, output bit legal, output bit wr,
                                    output bit r1, output bit r2);
      logic [6:0] o;
      o = inst[6:0];
      legal = o inside {LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OPIMM, OP, MISC, SYSTEM, OPIMM32, OP32};
      wr = legal && (o inside {LUI, AUIPC, JAL, JALR, LOAD, OPIMM, OP, OPIMM32, OP32}) && (inst[11:7] != 0);
      r1 = legal && !(o inside {LUI, AUIPC, JAL});
      r2 = o inside {BRANCH, STORE, OP, OP32};
   endfunction

   function automatic logic [63:0] m_opnd(input int rs);
      if (rs == 0) return 64'd0;
      if (wb_en && (wb_rd == rs)) return wb_data;
      return rf[rs];
   endfunction

   function automatic ent_t m_build(input logic [31:0] inst, input logic [63:0] pc);
      ent_t e;
      int   si;
      bit   lg, wr, r1, r2;
      classify(inst, lg, wr, r1, r2);
      si    = int'(inst);
      e.pc  = pc;
      e.rs1 = m_opnd(int'(inst[19:15]));
      e.rs2 = m_opnd(int'(inst[24:20]));
      e.ii  = longint'(si >>> 20);
      e.is  = longint'(((si >>> 20) & -32) | ((si >>> 7) & 31));
      e.ib  = longint'(((si >>> 19) & -4096) | (((si >>> 7) & 1) << 11) |
                       (((si >>> 25) & 63) << 5) | (((si >>> 8) & 15) << 1));
      e.iu  = longint'(si & -4096);
      e.ij  = longint'(((si >>> 11) & -1048576) | (((si >>> 12) & 255) << 12) |
                       (((si >>> 20) & 1) << 11) | (((si >>> 21) & 1023) << 1));
      e.opc = inst[6:0];
      e.f3  = inst[14:12];
      e.f7  = inst[31:25];
      e.rd  = inst[11:7];
      e.ill = !lg;
      e.wr  = wr;
      return e;
   endfunction

   function automatic bit m_src_hz(input int rs);
      if (rs == 0) return 1'b0;
      if (m_v && m_held.wr && (m_held.rd == rs)) return 1'b1;
      if (m_pend[rs] >= 2) return 1'b1;
      if ((m_pend[rs] == 1) && !(wb_en && (wb_rd == rs))) return 1'b1;
      return 1'b0;
   endfunction

   function automatic bit m_ready();
      bit lg, wr, r1, r2, hz;
      classify(in_inst, lg, wr, r1, r2);
      hz = (r1 && m_src_hz(int'(in_inst[19:15]))) || (r2 && m_src_hz(int'(in_inst[24:20]))) ||
           (wr && (m_pend[in_inst[11:7]] == 3));
      return reset && !flush && (!m_v || out_ready) && !(in_valid && hz);
   endfunction

   function automatic void model_update();
      bit rdy, fire, dec;
      rdy  = m_ready();
      fire = m_v && out_ready;
      if (!reset) begin
         m_v = 0;
         m_held = '{default: '0};
         foreach (m_pend[r]) m_pend[r] = 0;
         retire_q.delete();
         return;
      end
      if (flush) begin
         m_v = 0;
         foreach (m_pend[r]) m_pend[r] = 0;
         retire_q.delete();
         return;
      end
      dec = wb_en && (wb_rd != 0) && (m_pend[wb_rd] > 0);
      if (fire && m_held.wr) begin
         m_pend[m_held.rd]++;
         retire_q.push_back(int'(m_held.rd));
      end
      if (dec) m_pend[wb_rd]--;
      if (in_valid && rdy) begin
         m_held = m_build(in_inst, in_pc);
         m_v = 1;
      end else if (fire) begin
         m_v = 0;
      end
   endfunction

   task automatic cyc();
      model_update();
      @(posedge clock);
      @(negedge clock);
   endtask

   task automatic do_reset();
      reset = 1'b0; flush = 1'b0; wb_en = 1'b0; out_ready = 1'b1;
      in_valid = 1'b1; in_inst = 32'h00500093; in_pc = 64'h0;
      #1 chk("reset_in_ready", in_ready, 1'b0);
      cyc();
      chk("reset_out_valid", out_valid, 1'b0);
      chk("reset_out_pc", out_pc, 64'd0);
      chk("reset_out_imm_i", out_imm_i, 64'd0);
      cyc();
      reset = 1'b1; in_valid = 1'b0;
   endtask

   task automatic check_outs();
      chk("m_valid", out_valid, m_v);
      chk("m_pc", out_pc, m_held.pc);
      chk("m_rs1", out_rs1, m_held.rs1);
      chk("m_rs2", out_rs2, m_held.rs2);
      chk("m_imm_i", out_imm_i, m_held.ii);
      chk("m_imm_s", out_imm_s, m_held.is);
      chk("m_imm_b", out_imm_b, m_held.ib);
      chk("m_imm_u", out_imm_u, m_held.iu);
      chk("m_imm_j", out_imm_j, m_held.ij);
      chk("m_opcode", out_opcode, m_held.opc);
      chk("m_funct3", out_funct3, m_held.f3);
      chk("m_funct7", out_funct7, m_held.f7);
      chk("m_rd", out_rd, m_held.rd);
      chk("m_illegal", out_illegal, m_held.ill);
   endtask

   initial begin
      foreach (rf[r]) rf[r] = {$urandom, $urandom};
      rf[1] = 64'hAAAA_0000_0000_AAAA;
      ops = '{LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OPIMM, OP, MISC, SYSTEM,
              OPIMM32, OP32, 7'h7F, 7'h00};
      tbl = '{
         '{32'h00500093, 64'd5, 64'h800, 64'h0050_0000, 1'b0, 7'h13},
         '{32'hFFF00093, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFE0, 64'hFFFF_FFFF_FFF0_0000, 1'b0, 7'h13},
         '{32'hFE000EE3, 64'hFFFF_FFFF_FFFF_FFE0, 64'hFFFF_FFFF_FFFF_FFFC, 64'hFFFF_FFFF_FE00_0000, 1'b0, 7'h63},
         '{32'h800000B7, 64'hFFFF_FFFF_FFFF_F800, 64'hFFFF_FFFF_FFFF_F800, 64'hFFFF_FFFF_8000_0000, 1'b0, 7'h37},
         '{32'h0000007F, 64'd0, 64'd0, 64'd0, 1'b1, 7'h7F},
         '{32'h0000001B, 64'd0, 64'd0, 64'd0, 1'b0, 7'h1B},
         '{32'h0000003B, 64'd0, 64'd0, 64'd0, 1'b0, 7'h3B}
      };
      reset = 1'b0; in_valid = 1'b0; in_inst = '0; in_pc = '0; flush = 1'b0;
      wb_en = 1'b0; wb_rd = '0; wb_data = '0; out_ready = 1'b0;
      @(negedge clock);

      for (int i = 0; i < 7; i++) begin
         do_reset();
         in_valid = 1'b1; in_inst = tbl[i].inst; in_pc = 64'h1000 + 64'(i * 4); out_ready = 1'b1;
         #1 chk("tbl_ready", in_ready, 1'b1);
         cyc();
         in_valid = 1'b0;
         chk("tbl_valid", out_valid, 1'b1);
         chk("tbl_pc", out_pc, 64'h1000 + 64'(i * 4));
         chk("tbl_imm_i", out_imm_i, tbl[i].ii);
         chk("tbl_imm_b", out_imm_b, tbl[i].ib);
         chk("tbl_imm_u", out_imm_u, tbl[i].iu);
         chk("tbl_illegal", out_illegal, tbl[i].ill);
         chk("tbl_opcode", out_opcode, tbl[i].opc);
      end

      // RAW: ADDI x1 then ADD x2,x1,x1, released by forwarding in the wb cycle
      do_reset();
      in_valid = 1'b1; in_inst = 32'h00500093; in_pc = 64'h100; out_ready = 1'b1;
      #1 chk("addi_ready", in_ready, 1'b1);
      cyc();
      chk("addi_valid", out_valid, 1'b1);
      chk("addi_imm_i", out_imm_i, 64'd5);
      chk("addi_rd", out_rd, 5'd1);
      chk("addi_rs1", out_rs1, 64'd0);
      in_inst = 32'h00108133; in_pc = 64'h104;
      #1 chk("raw_held_stall", in_ready, 1'b0);
      cyc();
      chk("raw_drained", out_valid, 1'b0);
      #1 chk("raw_pend_stall", in_ready, 1'b0);
      cyc();
      wb_en = 1'b1; wb_rd = 5'd1; wb_data = 64'h1234;
      #1 chk("raw_wb_ready", in_ready, 1'b1);
      cyc();
      wb_en = 1'b0; in_valid = 1'b0;
      chk("raw_valid", out_valid, 1'b1);
      chk("raw_rs1_fwd", out_rs1, 64'h1234);
      chk("raw_rs2_fwd", out_rs2, 64'h1234);
      chk("raw_rd", out_rd, 5'd2);

      // Backpressure, then reset while stalled
      do_reset();
      in_valid = 1'b1; in_inst = 32'h00500093; in_pc = 64'h200; out_ready = 1'b1;
      cyc();
      out_ready = 1'b0; in_inst = 32'h00700213; in_pc = 64'h204;
      for (int k = 0; k < 3; k++) begin
         #1 chk("bp_ready", in_ready, 1'b0);
         chk("bp_valid", out_valid, 1'b1);
         chk("bp_pc", out_pc, 64'h200);
         chk("bp_imm", out_imm_i, 64'd5);
         cyc();
      end
      out_ready = 1'b1;
      #1 chk("bp_release_ready", in_ready, 1'b1);
      cyc();
      chk("bp_next_valid", out_valid, 1'b1);
      chk("bp_next_pc", out_pc, 64'h204);
      chk("bp_next_imm", out_imm_i, 64'd7);
      chk("bp_next_rd", out_rd, 5'd4);
      in_valid = 1'b0; out_ready = 1'b0;
      cyc();
      chk("bp_hold_valid", out_valid, 1'b1);
      reset = 1'b0;
      cyc();
      chk("rst_stall_valid", out_valid, 1'b0);
      chk("rst_stall_pc", out_pc, 64'd0);
      reset = 1'b1;

      // Saturation of the x3 counter
      do_reset();
      out_ready = 1'b1; in_valid = 1'b1; in_inst = 32'h00100193; in_pc = 64'h300;
      for (int k = 0; k < 3; k++) begin
         #1 chk("sat_issue_ready", in_ready, 1'b1);
         cyc();
      end
      in_valid = 1'b0;
      cyc();
      in_valid = 1'b1;
      #1 chk("sat_full", in_ready, 1'b0);
      cyc();
      #1 chk("sat_full2", in_ready, 1'b0);
      wb_en = 1'b1; wb_rd = 5'd3; wb_data = 64'h55;
      chk("sat_wb_cycle", in_ready, 1'b0);
      cyc();
      wb_en = 1'b0;
      #1 chk("sat_after_wb", in_ready, 1'b1);
      cyc();
      in_valid = 1'b0;
      chk("sat_accept_valid", out_valid, 1'b1);
      chk("sat_accept_rd", out_rd, 5'd3);

      // Flush with held entry and pend[5]=2, flush wins over same-cycle wb
      do_reset();
      out_ready = 1'b1; in_valid = 1'b1; in_inst = 32'h00100293; in_pc = 64'h400;
      cyc(); cyc(); cyc();
      out_ready = 1'b0; in_valid = 1'b0;
      cyc();
      chk("flush_pre_valid", out_valid, 1'b1);
      flush = 1'b1; wb_en = 1'b1; wb_rd = 5'd5; in_valid = 1'b1; in_inst = 32'h00028313;
      #1 chk("flush_ready", in_ready, 1'b0);
      cyc();
      flush = 1'b0; wb_en = 1'b0; out_ready = 1'b1;
      chk("flush_valid", out_valid, 1'b0);
      #1 chk("flush_after_ready", in_ready, 1'b1);
      cyc();
      chk("flush_rd_valid", out_valid, 1'b1);
      chk("flush_rd", out_rd, 5'd6);
      chk("flush_rs1", out_rs1, rf[5]);

      // Illegal instruction naming a pending source never stalls
      in_inst = 32'h00500093;
      cyc();
      in_inst = 32'h0010807F;
      #1 chk("ill_ready", in_ready, 1'b1);
      cyc();
      in_valid = 1'b0;
      chk("ill_flag", out_illegal, 1'b1);
      chk("ill_valid", out_valid, 1'b1);
      chk("ill_opcode", out_opcode, 7'h7F);

      // Randomized traffic against the reference model
      do_reset();
      for (int n = 0; n < 3000; n++) begin
         logic [31:0] ins;
         int          rdn, held_same;
         check_outs();
         in_valid  = ($urandom % 4) != 0;
         out_ready = ($urandom % 4) != 0;
         flush     = ($urandom % 64) == 0;
         ins = $urandom;
         ins[6:0]   = ops[$urandom % 15];
         ins[19:15] = 5'($urandom % 8);
         ins[24:20] = 5'($urandom % 8);
         rdn = int'($urandom % 8);
         held_same = (m_v && m_held.wr && (m_held.rd == rdn)) ? 1 : 0;
         if (m_pend[rdn] + held_same >= 3) rdn = 0;
         ins[11:7] = 5'(rdn);
         in_inst = ins;
         in_pc = {$urandom, $urandom};
         if ((retire_q.size() > 0) && ($urandom % 2 == 1)) begin
            wb_en = 1'b1;
            wb_rd = 5'(retire_q.pop_front());
         end else if ($urandom % 16 == 0) begin
            wb_en = 1'b1;
            wb_rd = 5'($urandom % 8);
         end else begin
            wb_en = 1'b0;
         end
         wb_data = {$urandom, $urandom};
         #1 chk("rand_in_ready", in_ready, m_ready());
         cyc();
      end
      check_outs();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/decode_stage.md
# decode_stage

Parametrised RISC-V decode/operand-fetch pipeline stage between fetch and execute. It latches an instruction with valid/ready handshakes on both sides and reads operands through an external combinational register-file port, forwarding the same-cycle writeback. It pre-builds all five sign-extended immediates at XLEN width and stalls on read-after-write hazards using a per-register pending-write scoreboard.

## Interface
- XLEN, 32, datapath width; 32 or 64 (64 also decodes OP-IMM-32 0011011 / OP-32 0111011)
- PEND_W, 2, width of each per-register pending-write counter
- clock  in  1  clock
- reset  in  1  reset, synchronous, active-low
- in_valid  in  1  fetch offers in_inst/in_pc
- in_ready  out  1  stage accepts this cycle
- in_inst  in  32  instruction word
- in_pc  in  XLEN  instruction address
- flush  in  1  kill held entry, clear scoreboard
- rf_rs1_sel / rf_rs2_sel  out  5  register-file read selects = in_inst[19:15] / [24:20]
- rf_rs1_data / rf_rs2_data  in  XLEN  combinational read data
- wb_en  in  1  writeback this cycle; also retires one pending write
- wb_rd  in  5  writeback destination
- wb_data  in  XLEN  writeback value
- out_valid  out  1  held entry valid
- out_ready  in  1  execute accepts held entry
- out_pc, out_rs1, out_rs2  out  XLEN  latched PC and operands
- out_imm_i, out_imm_s, out_imm_b, out_imm_u, out_imm_j  out  XLEN  sign-extended immediates
- out_opcode 7, out_funct3 3, out_funct7 7, out_rd 5  out  instruction fields
- out_illegal  out  1  opcode not in legal set

## Operation
- Class decode on in_inst[6:0]. writes_rd: LUI, AUIPC, JAL, JALR, LOAD, OP-IMM, OP (+32-bit variants at XLEN=64), and rd≠0. reads_rs1: everything legal except LUI/AUIPC/JAL. reads_rs2: BRANCH, STORE, OP, OP-32.
- Legal set: above plus BRANCH, STORE, MISC-MEM 0001111, SYSTEM 1110011. An illegal instruction passes through with out_illegal=1, reads nothing, writes nothing, never stalls.
- Immediates (all sign-extended from inst[31]): I={31:20}; S={31:25,11:7}; B={31,7,30:25,11:8,0}; U={31:12,12'b0}; J={31,19:12,20,30:21,0}.
- Operand select per source rs: rs=0 → 0; else wb_en && wb_rd==rs → wb_data; else rf data.
- Scoreboard: pend[1..31], PEND_W bits each. Increment pend[out_rd] on out fire (out_valid&&out_ready) when the held entry writes_rd. Decrement pend[wb_rd] on wb_en with wb_rd≠0 and pend>0. Increment and decrement of the same register in the same cycle → unchanged. wb_en with pend=0 → no change.
- hazard, per read source rs≠0: (a) out_valid and held entry writes_rd with out_rd==rs (even if firing); or (b) pend[rs]≥2; or (c) pend[rs]==1 and not (wb_en && wb_rd==rs). Structural: incoming writes_rd with pend[rd]==2^PEND_W−1 → hazard.
- in_ready = reset && !flush && (!out_valid || out_ready) && !(in_valid && hazard).
- Accept (in_valid&&in_ready): all out_* loaded, out_valid←1. Out fire without accept: out_valid←0. Stalled entry: out_* held stable.
- flush: out_valid←0, all pend←0, no accept that cycle. Controller asserts it only when all downstream in-flight writers are squashed.

## Timing
- Reset: out_valid=0, all out_* data=0, pend all 0, in_ready=0 while reset low. Reset mid-stall drops the held entry.
- Latency 1 cycle accept→out_valid; throughput 1/cycle with no hazard.
- in_ready depends combinationally on in_valid, in_inst, wb_*, out_ready; rf selects are pure wiring.
- Dependent back-to-back ALU ops stall until the producer's wb_en cycle (forwarded then), not later.
- Simultaneous flush and wb_en: flush wins (counters 0).

## Test plan
- Reset, then ADDI x1,x0,5 (0x00500093) with in_valid and out_ready=1 → next cycle out_valid=1, out_imm_i=5, out_rd=1, out_rs1=0; following cycle pend[1]=1.
- Immediates: inst 0xFFF00093 → imm_i=all-ones; BEQ 0xFE000EE3 → imm_b=−4; LUI 0x800000B7 at XLEN=64 → imm_u=0xFFFFFFFF80000000.
- RAW: ADDI x1 then ADD x2,x1,x1 → in_ready=0 while x1 held/pending; in wb_en cycle (wb_rd=1, wb_data=0x1234) accept with out_rs1=out_rs2=0x1234.
- Backpressure: out_ready=0 for 3 cycles → out_* stable, in_ready=0; release → one fire, next accept same cycle.
- Saturation PEND_W=2: three x3 writers issued with no wb → fourth x3 writer stalls; one wb_en x3 → accepted next.
- flush with held entry and pend[5]=2 → out_valid=0, pend all 0, reader of x5 accepted next cycle; illegal 0x0000007F → out_illegal=1, no stall.
